// File: rtl/noc_pkg.sv
// Shared router parameters and the switch-allocator per-output state type.
package noc_pkg;

  localparam int unsigned PORT_N = 5;
  localparam int unsigned PORT_W = $clog2(PORT_N);

  typedef enum logic {
    IDLE,
    LOCKED
  } sw_state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping at PORT_N-1.
module rr_arb #(
  parameter int unsigned PORT_N = noc_pkg::PORT_N,
  parameter int unsigned PORT_W = noc_pkg::PORT_W
) (
  input  logic [PORT_N-1:0] req_i,
  input  logic [PORT_W-1:0] ptr_i,
  output logic [PORT_N-1:0] gnt_o,
  output logic [PORT_W-1:0] gnt_idx_o
);

  // Scan from the farthest slot back towards ptr so the nearest requester is written last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = int'(PORT_N) - 1; k >= 0; k--) begin
      automatic int idx = int'(ptr_i) + k;
      if (idx >= int'(PORT_N)) idx = idx - int'(PORT_N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PORT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Switch allocator: per-output round-robin arbitration of head flits with a wormhole
// lock held until the owner's tail flit crosses.
module sw_alloc
  import noc_pkg::*;
#(
  parameter int unsigned PORT_N = noc_pkg::PORT_N,
  parameter int unsigned PORT_W = noc_pkg::PORT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_N-1:0]              req_i,
  input  logic [PORT_N-1:0][PORT_W-1:0]  port_i,
  input  logic [PORT_N-1:0]              head_i,
  input  logic [PORT_N-1:0]              tail_i,
  input  logic [PORT_N-1:0]              rdy_i,
  output logic [PORT_N-1:0][PORT_N-1:0]  grt_o,
  output logic [PORT_N-1:0]              xfer_o,
  output logic [PORT_N-1:0]              busy_o,
  output logic                           err_o
);

  sw_state_t         state_q [PORT_N];
  sw_state_t         state_d [PORT_N];
  logic [PORT_W-1:0] owner_q [PORT_N];
  logic [PORT_W-1:0] owner_d [PORT_N];
  logic [PORT_W-1:0] ptr_q   [PORT_N];
  logic [PORT_W-1:0] ptr_d   [PORT_N];
  logic              err_q, err_d;

  logic [PORT_N-1:0] owns_any;
  logic [PORT_N-1:0] arb_req [PORT_N];
  logic [PORT_N-1:0] arb_gnt [PORT_N];
  logic [PORT_W-1:0] arb_idx [PORT_N];

  // Grant matrix and busy flags decode straight from the lock registers.
  always_comb begin
    grt_o  = '0;
    busy_o = '0;
    for (int j = 0; j < int'(PORT_N); j++) begin
      if (state_q[j] == LOCKED) begin
        busy_o[j]             = 1'b1;
        grt_o[owner_q[j]][j]  = 1'b1;
      end
    end
  end

  always_comb begin
    owns_any = '0;
    xfer_o   = '0;
    for (int i = 0; i < int'(PORT_N); i++) begin
      owns_any[i] = |grt_o[i];
      xfer_o[i]   = req_i[i] & (|(grt_o[i] & rdy_i));
    end
  end

  assign err_o = err_q;

  // An input already holding an output may not compete for another one.
  always_comb begin
    for (int j = 0; j < int'(PORT_N); j++) begin
      arb_req[j] = '0;
      for (int i = 0; i < int'(PORT_N); i++) begin
        arb_req[j][i] = req_i[i] & head_i[i] & (port_i[i] == PORT_W'(j)) & ~owns_any[i];
      end
    end
  end

  for (genvar g = 0; g < PORT_N; g++) begin : g_arb
    rr_arb #(
      .PORT_N (PORT_N),
      .PORT_W (PORT_W)
    ) u_rr_arb (
      .req_i     (arb_req[g]),
      .ptr_i     (ptr_q[g]),
      .gnt_o     (arb_gnt[g]),
      .gnt_idx_o (arb_idx[g])
    );
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    for (int i = 0; i < int'(PORT_N); i++) begin
      if (req_i[i] && (32'(port_i[i]) >= PORT_N)) err_d = 1'b1;
    end
    for (int j = 0; j < int'(PORT_N); j++) begin
      unique case (state_q[j])
        IDLE: begin
          if (|arb_gnt[j]) begin
            state_d[j] = LOCKED;
            owner_d[j] = arb_idx[j];
            ptr_d[j]   = (arb_idx[j] == PORT_W'(PORT_N - 1)) ? '0 : arb_idx[j] + PORT_W'(1);
          end
        end
        LOCKED: begin
          // The owner's xfer can only be on this output, so it marks the tail crossing here.
          if (xfer_o[owner_q[j]] && tail_i[owner_q[j]]) state_d[j] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(PORT_N); j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < PORT_N; g++) begin : g_chk
    a_row_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grt_o[g]));
  end

endmodule

// File: tb/tb_sw_alloc.sv
// Bench for sw_alloc: directed scenarios with constant expectations, then randomized
// traffic against a behavioural lock/owner/pointer model.
module tb_sw_alloc;
  import noc_pkg::*;

  localparam int N = int'(PORT_N);

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N-1:0]               req, head, tail, rdy;
  logic [N-1:0][PORT_W-1:0]   port;
  logic [N-1:0][N-1:0]        grt;
  logic [N-1:0]               xfer, busy;
  logic                       err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit m_lock [N];
  int m_own  [N];
  int m_ptr  [N];
  bit m_err;

  always #5 clk = ~clk;

  sw_alloc u_dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .port_i (port),
    .head_i (head),
    .tail_i (tail),
    .rdy_i  (rdy),
    .grt_o  (grt),
    .xfer_o (xfer),
    .busy_o (busy),
    .err_o  (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req  = '0;
    head = '0;
    tail = '0;
    rdy  = '1;
    port = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < N; j++) begin
      m_lock[j] = 1'b0;
      m_own[j]  = 0;
      m_ptr[j]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic int col_owner(input int j);
    int o = -1;
    for (int i = 0; i < N; i++) if (grt[i][j]) o = i;
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit n_lock [N];
    int n_own  [N];
    int n_ptr  [N];
    bit owns   [N];
    for (int i = 0; i < N; i++) owns[i] = 1'b0;
    for (int j = 0; j < N; j++) if (m_lock[j]) owns[m_own[j]] = 1'b1;
    for (int j = 0; j < N; j++) begin
      n_lock[j] = m_lock[j];
      n_own[j]  = m_own[j];
      n_ptr[j]  = m_ptr[j];
      if (m_lock[j]) begin
        if (req[m_own[j]] && rdy[j] && tail[m_own[j]]) n_lock[j] = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          int i = (m_ptr[j] + k) % N;
          if (!n_lock[j] && req[i] && head[i] && int'(port[i]) == j && !owns[i]) begin
            n_lock[j] = 1'b1;
            n_own[j]  = i;
            n_ptr[j]  = (i + 1) % N;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) if (req[i] && int'(port[i]) >= N) m_err = 1'b1;
    for (int j = 0; j < N; j++) begin
      m_lock[j] = n_lock[j];
      m_own[j]  = n_own[j];
      m_ptr[j]  = n_ptr[j];
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = '1;
    head = '1;
    tail = '0;
    rdy  = '1;
    for (int i = 0; i < N; i++) port[i] = PORT_W'(i);
    #2;
    total++; if (grt !== '0) begin bad++; $display("FAIL reset_grt: got %h want 0", grt); end
    total++; if (busy !== '0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (xfer !== '0) begin bad++; $display("FAIL reset_xfer: got %b want 0", xfer); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    tick();
    total++; if (grt !== '0) begin bad++; $display("FAIL reset_hold_grt: got %h want 0", grt); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [N-1:0][N-1:0] exp;
    idle_inputs();
    req[1] = 1'b1; port[1] = 3'd3; head[1] = 1'b1;
    #1;
    total++; if (grt !== '0) begin bad++; $display("FAIL basic_pre_grt: got %h want 0", grt); end
    tick();
    exp = '0; exp[1][3] = 1'b1;
    total++; if (grt !== exp) begin bad++; $display("FAIL basic_grt: got %h want %h", grt, exp); end
    total++; if (busy !== 5'b01000) begin bad++; $display("FAIL basic_busy: got %b want 01000", busy); end
    total++; if (xfer !== 5'b00010) begin bad++; $display("FAIL basic_xfer: got %b want 00010", xfer); end
    head[1] = 1'b0; tail[1] = 1'b1;
    #1;
    total++; if (xfer !== 5'b00010) begin bad++; $display("FAIL basic_tail_xfer: got %b want 00010", xfer); end
    tick();
    idle_inputs();
    #1;
    total++; if (busy !== '0) begin bad++; $display("FAIL basic_release: got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_round_robin();
    int f [N];
    int exp_o, got_o, k, r;
    logic [N-1:0] x;
    for (int i = 0; i < N; i++) f[i] = 0;
    idle_inputs();
    for (int c = 0; c <= 12; c++) begin
      for (int i = 0; i < N; i++) begin
        bit act = (i % 2 == 0) && (f[i] < 3);
        req[i]  = act;
        port[i] = 3'd1;
        head[i] = act && (f[i] == 0);
        tail[i] = act && (f[i] == 2);
      end
      #1;
      if (c == 0) exp_o = -1;
      else begin
        k = (c - 1) / 4;
        r = (c - 1) % 4;
        exp_o = (r == 3) ? -1 : 2 * k;
      end
      got_o = col_owner(1);
      total++;
      if (got_o !== exp_o) begin
        bad++; $display("FAIL rr_owner c=%0d: got %0d want %0d", c, got_o, exp_o);
      end
      x = xfer;
      tick();
      for (int i = 0; i < N; i++) if (x[i]) f[i]++;
    end
    // Pointer must have wrapped to 0: input 0 beats input 4.
    idle_inputs();
    req[0] = 1'b1; head[0] = 1'b1; tail[0] = 1'b1; port[0] = 3'd1;
    req[4] = 1'b1; head[4] = 1'b1; tail[4] = 1'b1; port[4] = 3'd1;
    tick();
    got_o = col_owner(1);
    total++; if (got_o !== 0) begin bad++; $display("FAIL rr_wrap: got %0d want 0", got_o); end
    do_reset();
  endtask

  task automatic test_bubble();
    logic [N-1:0] exp_col, got_col, exp_x;
    idle_inputs();
    for (int c = 0; c <= 8; c++) begin
      req = '0; head = '0; tail = '0;
      port[2] = 3'd2; port[0] = 3'd2;
      if (c <= 1) begin req[2] = 1'b1; head[2] = 1'b1; end
      if (c == 5) begin req[2] = 1'b1; tail[2] = 1'b1; end
      if (c >= 2 && c <= 7) begin req[0] = 1'b1; head[0] = 1'b1; tail[0] = 1'b1; end
      #1;
      for (int i = 0; i < N; i++) got_col[i] = grt[i][2];
      exp_col = (c >= 1 && c <= 5) ? 5'b00100 : (c == 7) ? 5'b00001 : 5'b00000;
      exp_x   = (c == 1 || c == 5) ? 5'b00100 : (c == 7) ? 5'b00001 : 5'b00000;
      total++;
      if (got_col !== exp_col) begin
        bad++; $display("FAIL bubble_col c=%0d: got %b want %b", c, got_col, exp_col);
      end
      total++;
      if (xfer !== exp_x) begin
        bad++; $display("FAIL bubble_xfer c=%0d: got %b want %b", c, xfer, exp_x);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_stall();
    logic exp_b, exp_x;
    idle_inputs();
    for (int c = 0; c <= 7; c++) begin
      req = '0; head = '0; tail = '0; rdy = '1;
      port[3] = 3'd0;
      if (c <= 1) begin req[3] = 1'b1; head[3] = 1'b1; end
      if (c >= 2 && c <= 6) begin req[3] = 1'b1; tail[3] = 1'b1; end
      if (c >= 2 && c <= 5) rdy[0] = 1'b0;
      #1;
      exp_b = (c >= 1 && c <= 6);
      exp_x = (c == 1 || c == 6);
      total++;
      if (busy[0] !== exp_b) begin
        bad++; $display("FAIL stall_busy c=%0d: got %b want %b", c, busy[0], exp_b);
      end
      total++;
      if (xfer[3] !== exp_x) begin
        bad++; $display("FAIL stall_xfer c=%0d: got %b want %b", c, xfer[3], exp_x);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_single_all();
    logic [N-1:0][N-1:0] exp;
    idle_inputs();
    exp = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1; head[i] = 1'b1; tail[i] = 1'b1;
      port[i] = PORT_W'((i + 1) % N);
      exp[i][(i + 1) % N] = 1'b1;
    end
    tick();
    total++; if (grt !== exp) begin bad++; $display("FAIL single_grt: got %h want %h", grt, exp); end
    total++; if (busy !== '1) begin bad++; $display("FAIL single_busy: got %b want 11111", busy); end
    total++; if (xfer !== '1) begin bad++; $display("FAIL single_xfer: got %b want 11111", xfer); end
    tick();
    idle_inputs();
    #1;
    total++; if (grt !== '0) begin bad++; $display("FAIL single_release: got %h want 0", grt); end
    do_reset();
  endtask

  task automatic test_async_reset_err();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; head[i] = 1'b1; port[i] = PORT_W'(4 - i);
    end
    tick();
    total++; if (busy !== 5'b11100) begin bad++; $display("FAIL arst_locked: got %b want 11100", busy); end
    #1 rst = 1'b1;
    #1;
    total++; if (grt !== '0) begin bad++; $display("FAIL arst_grt: got %h want 0", grt); end
    total++; if (busy !== '0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    #1 rst = 1'b0;
    idle_inputs();
    tick();
    req[0] = 1'b1; head[0] = 1'b1; port[0] = 3'd7;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", err); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
    total++; if (grt !== '0) begin bad++; $display("FAIL err_nogrant: got %h want 0", grt); end
    idle_inputs();
    tick();
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_random();
    logic [N-1:0][N-1:0] e_grt;
    logic [N-1:0]        e_busy, e_xfer;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        head[i] = ($urandom_range(0, 2) == 0);
        tail[i] = ($urandom_range(0, 2) == 0);
        rdy[i]  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) port[i] = PORT_W'($urandom_range(5, 7));
        else port[i] = PORT_W'($urandom_range(0, N - 1));
      end
      #1;
      e_grt = '0; e_busy = '0; e_xfer = '0;
      for (int j = 0; j < N; j++) begin
        if (m_lock[j]) begin
          e_grt[m_own[j]][j] = 1'b1;
          e_busy[j] = 1'b1;
          if (req[m_own[j]] && rdy[j]) e_xfer[m_own[j]] = 1'b1;
        end
      end
      total++;
      if (grt !== e_grt) begin
        bad++; $display("FAIL rand_grt c=%0d: got %h want %h", c, grt, e_grt);
      end
      total++;
      if (busy !== e_busy) begin
        bad++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, e_busy);
      end
      total++;
      if (xfer !== e_xfer) begin
        bad++; $display("FAIL rand_xfer c=%0d: got %b want %b", c, xfer, e_xfer);
      end
      total++;
      if (err !== m_err) begin
        bad++; $display("FAIL rand_err c=%0d: got %b want %b", c, err, m_err);
      end
      model_step();
      tick();
    end
    do_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_bubble();
    test_stall();
    test_single_all();
    test_async_reset_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_alloc.md
# sw_alloc

Switch allocator for the wormhole router crossbar. Each input channel presents at most one output-port request per cycle. Per output port, the block arbitrates round-robin among head-flit requests and locks the winner until its tail flit crosses. It drives the registered crossbar grant matrix and per-output busy flags, replacing ad-hoc request/grant resolution between input channels and the crossbar.

## Interface
Parameters:
- PORT_N, noc_pkg::PORT_N (5): number of router ports, inputs = outputs.
- PORT_W, noc_pkg::PORT_W ($clog2(PORT_N)): output-port index width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_i  in  [PORT_N]  input i holds a valid flit.
- port_i  in  [PORT_N][PORT_W]  requested output port of input i; meaningful only when req_i[i]=1.
- head_i  in  [PORT_N]  flit on input i is a head flit.
- tail_i  in  [PORT_N]  flit on input i is a tail flit; head and tail may both be 1 for a single-flit packet.
- rdy_i  in  [PORT_N]  output j can accept a flit this cycle (credit available).
- grt_o  out  [PORT_N][PORT_N]  grt_o[i][j]: input i owns output j. Registered.
- xfer_o  out  [PORT_N]  a flit from input i crosses this cycle. Combinational: grt_o[i][j] & req_i[i] & rdy_i[j] for the owned j.
- busy_o  out  [PORT_N]  output j is locked. Registered.
- err_o  out  1  sticky: a request with port_i >= PORT_N was seen. Cleared only by rst.

## Operation
Per-output state is IDLE or LOCKED, plus owner[PORT_W] and rr_ptr[PORT_W].

IDLE, output j:
- Candidates are inputs i with req_i[i] & head_i[i] & port_i[i]==j, excluding any input that currently owns another output.
- If there are candidates, the winner is the first candidate at or after rr_ptr, scanning upward and wrapping PORT_N-1 -> 0.
- At the next edge: owner <= winner, rr_ptr <= (winner+1) mod PORT_N, state LOCKED, grt_o[winner][j] <= 1, busy_o[j] <= 1.
- rdy_i does not gate arbitration. Credit gates only transfer.

LOCKED, output j:
- grt_o[owner][j] stays 1 regardless of req_i. A wormhole lock persists across bubbles.
- Non-head flits from the owner transfer whenever req_i & rdy_i[j].
- A transfer with tail_i[owner]=1 moves the output to IDLE at that edge and clears grt_o and busy_o.
- Requests from other inputs to a locked output are ignored. They do not move rr_ptr.

Illegal and invalid requests:
- A non-head request to an IDLE output is ignored. It gets no grant and raises no error.
- A request with port_i >= PORT_N is ignored for arbitration and sets err_o at the next edge.

Invariants:
- Each row and each column of grt_o is at most one-hot. Only one output is ever granted to an input, because each input names a single port.

## Timing
- Reset values: grt_o=0, busy_o=0, err_o=0, xfer_o=0 (grt_o=0 forces it), all states IDLE, all rr_ptr=0. Reset asserted mid-packet drops every lock immediately and asynchronously. Packets must be flushed upstream.
- Arbitration latency: head request in cycle t gives grt_o in cycle t+1. The earliest transfer of the head flit is cycle t+1.
- Single-flit packet: grant at t+1, transfer and release at the t+1 edge, IDLE in t+2.
- Release-to-regrant: tail transfer at cycle t, IDLE in t+1, arbitration in t+1, new grant at t+2. There is exactly one bubble cycle per packet boundary on an output.
- Tail transfer stalled by rdy_i[j]=0: the lock is held until the cycle where req & rdy & tail are all 1.
- Simultaneous events: different outputs arbitrate independently in the same cycle. A release and a new head request to the same output in the same cycle gives no grant that cycle; the head request wins no earlier than the next cycle.

## Structure
- noc_pkg: PORT_N and PORT_W are already present. Add sw_state_t (enum IDLE, LOCKED).
- Sub-module rr_arb: a PORT_N-wide round-robin arbiter with req, ptr, one-hot gnt and a gnt_idx output. Instantiate it PORT_N times, once per output, in a generate loop.
- Keep lock, owner and pointer registers in sw_alloc. rr_arb is purely combinational.

## Test plan
- Reset, then input 1 sends head to port 3 with rdy_i[3]=1 -> grt_o[1][3]=1 one cycle later, busy_o[3]=1, xfer_o[1]=1 that cycle.
- Inputs 0, 2 and 4 send simultaneous heads to port 1, each a 3-flit packet, rr_ptr=0 -> grant order 0, 2, 4; one bubble between packets; after packet 4, rr_ptr=0.
- Owner input 2 deasserts req_i for 3 cycles mid-packet while input 0 sends a head to the same port -> grt_o[2][j] stays 1, input 0 waits until input 2's tail is transferred.
- Tail flit presented with rdy_i[j]=0 for 4 cycles -> lock held, xfer_o=0 in those cycles, release on the first rdy_i=1 cycle.
- Single-flit packet (head=tail=1) on every input to distinct ports -> 5 grants in the same cycle, all released one edge later.
- rst asserted while 3 outputs are locked -> grt_o and busy_o go 0 without waiting for a clock edge. A request with port_i=7 (PORT_N=5) sets err_o, which stays 1 until rst.
